// File: rtl/fas_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fas_pkg                                                            |
// | Shared constants, FSM state type and bin-order helper for the      |
// | frequency-analysis pipeline.                                       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package fas_pkg;

   localparam int NPT    = 16;
   localparam int DW_DEF = 32;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } pts_state_t;

   // FFT output slot k holds bin bitrev4(k); reversing the 4-bit index maps back
   function automatic logic [3:0] bitrev4(input logic [3:0] k);
      return {k[0], k[1], k[2], k[3]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/fft_pts_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft_pts_if                                                         |
// | Frame capture strobe/data plus valid/ready output stream of the    |
// | FFT parallel-to-serial unloader.                                   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface fft_pts_if
   import fas_pkg::*;
#(
   parameter int DW = DW_DEF
);
   logic          fft_valid;
   logic [DW-1:0] fft_d0,  fft_d1,  fft_d2,  fft_d3;
   logic [DW-1:0] fft_d4,  fft_d5,  fft_d6,  fft_d7;
   logic [DW-1:0] fft_d8,  fft_d9,  fft_d10, fft_d11;
   logic [DW-1:0] fft_d12, fft_d13, fft_d14, fft_d15;
   logic          out_ready;
   logic          out_valid;
   logic [DW-1:0] out_d;
   logic [3:0]    out_idx;
   logic          out_last;
   logic          busy;
   logic          overflow;
   logic [7:0]    drop_cnt;

   // Unloader side
   modport slave (
      input  fft_valid,
      input  fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
      input  fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
      input  out_ready,
      output out_valid, out_d, out_idx, out_last, busy, overflow, drop_cnt
   );

   // FFT core / sink side
   modport master (
      output fft_valid,
      output fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
      output fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
      output out_ready,
      input  out_valid, out_d, out_idx, out_last, busy, overflow, drop_cnt
   );
endinterface
`default_nettype wire

// File: rtl/fft_frame_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft_frame_buf                                                      |
// | 16-word register bank: all slots written in one cycle, one word    |
// | read through a 4-bit indexed mux.                                  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fft_frame_buf
   import fas_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic                   clk_i,
   input  logic                   we_i,
   input  logic [NPT-1:0][DW-1:0] wdata_i,
   input  logic [3:0]             raddr_i,
   output logic [DW-1:0]          rdata_o
);
   // Frame contents carry no reset; occupancy is tracked by the owner
   logic [NPT-1:0][DW-1:0] mem_q;

   // Whole-frame capture in a single cycle
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];
endmodule
`default_nettype wire

// File: rtl/fft_pts.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft_pts                                                            |
// | Ping-pong FFT frame unloader: captures a 16-word frame on a strobe |
// | and streams it out one word per cycle over valid/ready.            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fft_pts
   import fas_pkg::*;
#(
   parameter int DW     = DW_DEF,
   parameter bit BITREV = 1'b0
) (
   input logic       CLK,
   input logic       RST,
   fft_pts_if.slave  bus
);
   pts_state_t state_q, state_d;
   logic [1:0] full_q, full_d;
   logic       rd_sel_q, rd_sel_d;
   logic [3:0] cnt_q, cnt_d;
   logic       ovf_q, ovf_d;
   logic [7:0] drop_q, drop_d;

   logic [NPT-1:0][DW-1:0] w_frame;
   logic [DW-1:0]          w_rdata [2];
   logic [1:0]             w_we;
   logic [1:0]             w_free;
   logic [3:0]             w_raddr;
   logic                   w_accept, w_release, w_other;
   logic                   w_cap, w_drop, w_wr_sel;

   assign w_frame[0]  = bus.fft_d0;
   assign w_frame[1]  = bus.fft_d1;
   assign w_frame[2]  = bus.fft_d2;
   assign w_frame[3]  = bus.fft_d3;
   assign w_frame[4]  = bus.fft_d4;
   assign w_frame[5]  = bus.fft_d5;
   assign w_frame[6]  = bus.fft_d6;
   assign w_frame[7]  = bus.fft_d7;
   assign w_frame[8]  = bus.fft_d8;
   assign w_frame[9]  = bus.fft_d9;
   assign w_frame[10] = bus.fft_d10;
   assign w_frame[11] = bus.fft_d11;
   assign w_frame[12] = bus.fft_d12;
   assign w_frame[13] = bus.fft_d13;
   assign w_frame[14] = bus.fft_d14;
   assign w_frame[15] = bus.fft_d15;

   // The buffer being drained counts as free in the cycle its last word is taken
   assign w_accept  = (state_q == SEND) && bus.out_ready;
   assign w_release = w_accept && (cnt_q == 4'd15);
   assign w_other   = ~rd_sel_q;
   assign w_free[0] = ~full_q[0] | (w_release & ~rd_sel_q);
   assign w_free[1] = ~full_q[1] | (w_release &  rd_sel_q);

   // Capture prefers the buffer not being read so a release never races a write
   assign w_wr_sel = w_free[w_other] ? w_other : rd_sel_q;
   assign w_cap    = bus.fft_valid && (w_free[0] || w_free[1]);
   assign w_drop   = bus.fft_valid && !(w_free[0] || w_free[1]);

   if (BITREV) begin : g_bitrev
      assign w_raddr = bitrev4(cnt_q);
   end else begin : g_natural
      assign w_raddr = cnt_q;
   end

   // Decode the capture target into per-buffer write enables
   always_comb begin
      w_we = 2'b00;
      if (w_cap) begin
         w_we[w_wr_sel] = 1'b1;
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_buf
      fft_frame_buf #(.DW(DW)) u_buf (
         .clk_i   (CLK),
         .we_i    (w_we[g]),
         .wdata_i (w_frame),
         .raddr_i (w_raddr),
         .rdata_o (w_rdata[g])
      );
   end

   // FSM state register
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, buffer occupancy, read pointer and drop accounting
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rd_sel_d = rd_sel_q;
      full_d   = full_q;
      if (w_release) begin
         full_d[rd_sel_q] = 1'b0;
      end
      if (w_cap) begin
         full_d[w_wr_sel] = 1'b1;
      end
      case (state_q)
         IDLE: begin
            if (|full_d) begin
               state_d  = SEND;
               cnt_d    = 4'd0;
               rd_sel_d = full_d[rd_sel_q] ? rd_sel_q : w_other;
            end
         end
         SEND: begin
            if (w_accept) begin
               if (cnt_q == 4'd15) begin
                  cnt_d = 4'd0;
                  if (full_d[w_other]) begin
                     rd_sel_d = w_other;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      ovf_d  = w_drop;
      drop_d = (w_drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
   end

   // Datapath registers
   always_ff @(posedge CLK) begin
      if (!RST) begin
         full_q   <= 2'b00;
         rd_sel_q <= 1'b0;
         cnt_q    <= 4'd0;
         ovf_q    <= 1'b0;
         drop_q   <= 8'd0;
      end else begin
         full_q   <= full_d;
         rd_sel_q <= rd_sel_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
      end
   end

   // Outputs come only from registers; the data path is zeroed while idle
   always_comb begin
      bus.out_valid = (state_q == SEND);
      bus.out_d     = (state_q == SEND) ? w_rdata[rd_sel_q] : '0;
      bus.out_idx   = (state_q == SEND) ? cnt_q : 4'd0;
      bus.out_last  = (state_q == SEND) && (cnt_q == 4'd15);
      bus.busy      = |full_q;
      bus.overflow  = ovf_q;
      bus.drop_cnt  = drop_q;
   end
endmodule
`default_nettype wire

// File: tb/tb_fft_pts.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fft_pts                                                         |
// | Self-checking bench: two unloaders (natural and bit-reversed       |
// | order) driven in lockstep against a frame-queue reference model.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fft_pts;
   localparam int DW = 32;
   typedef logic [DW-1:0] frame_t [16];

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fft_pts_if #(.DW(DW)) bus0 ();
   fft_pts_if #(.DW(DW)) bus1 ();

   fft_pts #(.DW(DW), .BITREV(1'b0)) u_dut0 (.CLK(clk), .RST(rst_n), .bus(bus0));
   fft_pts #(.DW(DW), .BITREV(1'b1)) u_dut1 (.CLK(clk), .RST(rst_n), .bus(bus1));

   assign bus1.fft_valid = bus0.fft_valid;
   assign bus1.out_ready = bus0.out_ready;
   assign bus1.fft_d0  = bus0.fft_d0;   assign bus1.fft_d1  = bus0.fft_d1;
   assign bus1.fft_d2  = bus0.fft_d2;   assign bus1.fft_d3  = bus0.fft_d3;
   assign bus1.fft_d4  = bus0.fft_d4;   assign bus1.fft_d5  = bus0.fft_d5;
   assign bus1.fft_d6  = bus0.fft_d6;   assign bus1.fft_d7  = bus0.fft_d7;
   assign bus1.fft_d8  = bus0.fft_d8;   assign bus1.fft_d9  = bus0.fft_d9;
   assign bus1.fft_d10 = bus0.fft_d10;  assign bus1.fft_d11 = bus0.fft_d11;
   assign bus1.fft_d12 = bus0.fft_d12;  assign bus1.fft_d13 = bus0.fft_d13;
   assign bus1.fft_d14 = bus0.fft_d14;  assign bus1.fft_d15 = bus0.fft_d15;

   int errors  = 0;
   int checks  = 0;
   int dut_acc = 0;

   // Reference model: frames held (at most two), position within the head frame
   frame_t exp_q[$];
   int     exp_pos   = 0;
   int     exp_drops = 0;
   bit     exp_ovf   = 1'b0;
   frame_t cur_frame;

   bit            prev_stall = 1'b0;
   logic [DW-1:0] prev_d;
   logic [3:0]    prev_idx;
   logic          prev_last;

   function automatic int brev(input int i);
      int r;
      r = 0;
      for (int b = 0; b < 4; b++) begin
         if (((i >> b) & 1) != 0) r = r | (1 << (3 - b));
      end
      return r;
   endfunction

   task automatic set_frame(input frame_t f);
      cur_frame = f;
      bus0.fft_d0  = f[0];  bus0.fft_d1  = f[1];  bus0.fft_d2  = f[2];  bus0.fft_d3  = f[3];
      bus0.fft_d4  = f[4];  bus0.fft_d5  = f[5];  bus0.fft_d6  = f[6];  bus0.fft_d7  = f[7];
      bus0.fft_d8  = f[8];  bus0.fft_d9  = f[9];  bus0.fft_d10 = f[10]; bus0.fft_d11 = f[11];
      bus0.fft_d12 = f[12]; bus0.fft_d13 = f[13]; bus0.fft_d14 = f[14]; bus0.fft_d15 = f[15];
   endtask

   task automatic rand_frame();
      frame_t f;
      for (int k = 0; k < 16; k++) f[k] = $urandom;
      set_frame(f);
   endtask

   // One clock: check the DUTs against the model mid-cycle, then advance the model
   task automatic tick();
      bit            act;
      logic [DW-1:0] w0, w1;
      logic [7:0]    dexp;
      @(negedge clk);
      act  = (exp_q.size() != 0);
      dexp = (exp_drops > 255) ? 8'd255 : 8'(exp_drops);
      checks++;
      if (bus0.out_valid !== act || bus1.out_valid !== act) begin
         errors++;
         $display("FAIL out_valid: got %b/%b want %b at %0t", bus0.out_valid, bus1.out_valid, act, $time);
      end
      checks++;
      if (bus0.busy !== act) begin
         errors++;
         $display("FAIL busy: got %b want %b at %0t", bus0.busy, act, $time);
      end
      checks++;
      if (bus0.overflow !== exp_ovf || bus1.overflow !== exp_ovf) begin
         errors++;
         $display("FAIL overflow: got %b/%b want %b at %0t", bus0.overflow, bus1.overflow, exp_ovf, $time);
      end
      checks++;
      if (bus0.drop_cnt !== dexp) begin
         errors++;
         $display("FAIL drop_cnt: got %0d want %0d at %0t", bus0.drop_cnt, dexp, $time);
      end
      if (act) begin
         w0 = exp_q[0][exp_pos];
         w1 = exp_q[0][brev(exp_pos)];
         checks++;
         if (bus0.out_d !== w0) begin
            errors++;
            $display("FAIL out_d natural idx %0d: got %h want %h", exp_pos, bus0.out_d, w0);
         end
         checks++;
         if (bus1.out_d !== w1) begin
            errors++;
            $display("FAIL out_d bitrev idx %0d: got %h want %h", exp_pos, bus1.out_d, w1);
         end
         checks++;
         if (bus0.out_idx !== 4'(exp_pos) || bus1.out_idx !== 4'(exp_pos)) begin
            errors++;
            $display("FAIL out_idx: got %0d/%0d want %0d", bus0.out_idx, bus1.out_idx, exp_pos);
         end
         checks++;
         if (bus0.out_last !== (exp_pos == 15)) begin
            errors++;
            $display("FAIL out_last idx %0d: got %b want %b", exp_pos, bus0.out_last, (exp_pos == 15));
         end
         if (prev_stall) begin
            checks++;
            if (bus0.out_d !== prev_d || bus0.out_idx !== prev_idx || bus0.out_last !== prev_last) begin
               errors++;
               $display("FAIL hold: got %h/%0d/%b want %h/%0d/%b", bus0.out_d, bus0.out_idx,
                        bus0.out_last, prev_d, prev_idx, prev_last);
            end
         end
      end
      if (bus0.out_valid === 1'b1 && bus0.out_ready === 1'b1) dut_acc++;
      prev_stall = act && !bus0.out_ready && rst_n;
      prev_d     = bus0.out_d;
      prev_idx   = bus0.out_idx;
      prev_last  = bus0.out_last;
      exp_ovf    = 1'b0;
      if (!rst_n) begin
         exp_q.delete();
         exp_pos   = 0;
         exp_drops = 0;
      end else begin
         if (act && bus0.out_ready) begin
            exp_pos++;
            if (exp_pos == 16) begin
               void'(exp_q.pop_front());
               exp_pos = 0;
            end
         end
         if (bus0.fft_valid) begin
            if (exp_q.size() < 2) exp_q.push_back(cur_frame);
            else begin
               exp_drops++;
               exp_ovf = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int max_cycles);
      bus0.out_ready = 1'b1;
      for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) tick();
      tick();
   endtask

   task automatic test_reset();
      bus0.fft_valid = 1'b0;
      bus0.out_ready = 1'b0;
      rand_frame();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus0.out_valid !== 1'b0 || bus0.out_d !== '0 || bus0.out_idx !== 4'd0 ||
          bus0.out_last !== 1'b0 || bus0.busy !== 1'b0 || bus0.overflow !== 1'b0 ||
          bus0.drop_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_state: got v=%b d=%h i=%0d l=%b b=%b o=%b c=%0d want all 0",
                  bus0.out_valid, bus0.out_d, bus0.out_idx, bus0.out_last, bus0.busy,
                  bus0.overflow, bus0.drop_cnt);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      frame_t f;
      for (int k = 0; k < 16; k++) f[k] = 32'h0001_0000 * k + k;
      set_frame(f);
      bus0.out_ready = 1'b1;
      bus0.fft_valid = 1'b1;
      tick();
      bus0.fft_valid = 1'b0;
      checks++;
      if (bus0.out_valid !== 1'b1 || bus0.out_idx !== 4'd0) begin
         errors++;
         $display("FAIL first_word_latency: got v=%b idx=%0d want v=1 idx=0", bus0.out_valid, bus0.out_idx);
      end
      checks++;
      if (bus1.out_d !== f[0]) begin
         errors++;
         $display("FAIL bitrev_idx0: got %h want %h", bus1.out_d, f[0]);
      end
      tick();
      checks++;
      if (bus1.out_idx !== 4'd1 || bus1.out_d !== f[8]) begin
         errors++;
         $display("FAIL bitrev_idx1: got %0d/%h want 1/%h", bus1.out_idx, bus1.out_d, f[8]);
      end
      tick();
      tick();
      checks++;
      if (bus1.out_idx !== 4'd3 || bus1.out_d !== f[12]) begin
         errors++;
         $display("FAIL bitrev_idx3: got %0d/%h want 3/%h", bus1.out_idx, bus1.out_d, f[12]);
      end
      drain(40);
   endtask

   task automatic test_backpressure();
      int start;
      rand_frame();
      bus0.out_ready = 1'b0;
      bus0.fft_valid = 1'b1;
      tick();
      bus0.fft_valid = 1'b0;
      start = dut_acc;
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
         bus0.out_ready = $urandom_range(0, 1);
         tick();
      end
      bus0.out_ready = 1'b0;
      repeat (3) tick();
      checks++;
      if (dut_acc - start != 16) begin
         errors++;
         $display("FAIL accept_count: got %0d want 16", dut_acc - start);
      end
   endtask

   task automatic test_pingpong_drop();
      bus0.out_ready = 1'b0;
      for (int n = 0; n < 3; n++) begin
         rand_frame();
         bus0.fft_valid = 1'b1;
         tick();
      end
      bus0.fft_valid = 1'b0;
      checks++;
      if (bus0.overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_pulse: got %b want 1", bus0.overflow);
      end
      tick();
      checks++;
      if (bus0.drop_cnt !== 8'd1 || bus0.overflow !== 1'b0) begin
         errors++;
         $display("FAIL drop_once: got cnt=%0d ovf=%b want cnt=1 ovf=0", bus0.drop_cnt, bus0.overflow);
      end
      drain(60);
   endtask

   task automatic test_simultaneous();
      bus0.out_ready = 1'b0;
      for (int n = 0; n < 2; n++) begin
         rand_frame();
         bus0.fft_valid = 1'b1;
         tick();
      end
      bus0.fft_valid = 1'b0;
      bus0.out_ready = 1'b1;
      for (int i = 0; i < 40 && !(exp_q.size() == 2 && exp_pos == 15); i++) tick();
      rand_frame();
      bus0.fft_valid = 1'b1;
      tick();
      bus0.fft_valid = 1'b0;
      checks++;
      if (bus0.overflow !== 1'b0 || bus0.drop_cnt !== 8'd1) begin
         errors++;
         $display("FAIL simultaneous_release: got ovf=%b cnt=%0d want ovf=0 cnt=1",
                  bus0.overflow, bus0.drop_cnt);
      end
      drain(80);
   endtask

   task automatic test_reset_midframe();
      rand_frame();
      bus0.out_ready = 1'b1;
      bus0.fft_valid = 1'b1;
      tick();
      bus0.fft_valid = 1'b0;
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if (bus0.out_valid !== 1'b0 || bus0.out_d !== '0 || bus0.out_idx !== 4'd0 ||
          bus0.out_last !== 1'b0 || bus0.busy !== 1'b0 || bus0.overflow !== 1'b0 ||
          bus0.drop_cnt !== 8'd0 || bus1.out_d !== '0) begin
         errors++;
         $display("FAIL midframe_reset: got v=%b d=%h i=%0d l=%b b=%b o=%b c=%0d want all 0",
                  bus0.out_valid, bus0.out_d, bus0.out_idx, bus0.out_last, bus0.busy,
                  bus0.overflow, bus0.drop_cnt);
      end
      rand_frame();
      bus0.fft_valid = 1'b1;
      tick();
      bus0.fft_valid = 1'b0;
      drain(40);
      bus0.out_ready = 1'b0;
      bus0.fft_valid = 1'b1;
      for (int n = 0; n < 302; n++) begin
         rand_frame();
         tick();
      end
      bus0.fft_valid = 1'b0;
      tick();
      checks++;
      if (bus0.drop_cnt !== 8'd255) begin
         errors++;
         $display("FAIL drop_saturation: got %0d want 255", bus0.drop_cnt);
      end
      drain(60);
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_pingpong_drop();
      test_simultaneous();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
